ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 9, address width; DATA_W, default 32, data width; DEPTH, default 128, number of implemented RAM words.
REQ-002 Ports SHALL be, per line, name / direction / width / meaning:
- clock  in  1  sole clock; all arbiter state is updated on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- pN_req  in  1  port N request (N = 0, 1); held high until pN_done
- pN_wr  in  1  port N: 1 = write, 0 = read; stable while pN_req is high
- pN_addr  in  ADDR_W  port N word address; stable while pN_req is high
- pN_wdata  in  DATA_W  port N write data; stable while pN_req is high
- pN_done  out  1  one-cycle completion pulse for port N
- pN_err  out  1  qualified by pN_done; address out of range
- pN_rdata  out  DATA_W  qualified by pN_done on a read
- mem_addr  out  ADDR_W  RAM address
- mem_wr  out  1  RAM write strobe
- mem_rd  out  1  RAM read strobe
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; registered by the RAM on the falling clock edge; high-Z when mem_rd is low

Function
REQ-003 The arbiter SHALL have a single one-hot or encoded FSM with states IDLE, ACCESS and RESP, and SHALL keep at most one access outstanding.
REQ-004 In IDLE, if any pN_req is high at a rising edge, the arbiter SHALL grant one port, latch its addr/wr/wdata into mem_* registers, and move to ACCESS.
REQ-005 Arbitration SHALL be round-robin using a last_grant register: on simultaneous requests the port not granted last wins; a lone requester always wins.
REQ-006 In ACCESS, which lasts exactly one cycle, mem_wr or mem_rd SHALL be high (never both), so the RAM acts on the falling edge inside that cycle.
REQ-007 On leaving ACCESS, the arbiter SHALL register mem_rdata into the granted pN_rdata, clear both strobes, and enter RESP.
REQ-008 In RESP, the granted pN_done SHALL be high for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-009 Latency SHALL be a fixed 3 rising edges from the pN_req-sampled edge to the edge that ends pN_done. Peak throughput SHALL be one access per 3 cycles.
REQ-010 A requester SHALL drop pN_req in the cycle after pN_done; a pN_req still high in IDLE SHALL be treated as a new request.
REQ-011 If a granted address is >= DEPTH, no strobe SHALL be raised, pN_done/pN_err SHALL assert with the same latency, and pN_rdata SHALL be 0.
REQ-012 pN_rdata SHALL hold its last value outside pN_done; it SHALL never propagate high-Z.
REQ-013 pN_err SHALL be 0 whenever pN_done is 0.
REQ-014 A request arriving while another access is in flight SHALL wait without loss until IDLE.
REQ-015 Write data SHALL pass unmodified. A write followed by a read to the same address SHALL return the written data.

Reset
REQ-016 Asserting reset_n low SHALL immediately force state=IDLE, mem_wr=0, mem_rd=0, mem_addr=0, mem_wdata=0, all pN_done=0, all pN_err=0, all pN_rdata=0, and last_grant=1 (so port 0 wins first).
REQ-017 Reset asserted during ACCESS before the falling edge SHALL suppress the RAM operation. No pN_done SHALL be issued for an aborted access.
REQ-018 After reset deasserts, the first request SHALL be sampled no earlier than the next rising edge.

Structure
REQ-019 The FSM state encoding and the DEPTH/ADDR_W/DATA_W defaults SHALL live in a shared package used by the ram and its clients.
REQ-020 The round-robin grant logic SHALL be a sub-module, rr_arb2 (inputs: req[1:0] and last; output: grant[1:0]); everything else SHALL be flat.

Verification
REQ-021 p0 writes 0x22450000 to address 0, then reads address 0 -> p0_done on cycle 3 of each access; read returns 0x22450000; p0_err = 0.
REQ-022 p0 and p1 request in the same cycle after reset (write 0x10F00010 to address 1, read address 1) -> p0 is served first, then p1; p1_rdata = 0x10F00010.
REQ-023 Both ports request continuously for 6 accesses -> grants alternate 0,1,0,1,0,1, and no strobe overlaps.
REQ-024 p1 reads address 200 -> no mem_rd; p1_done = 1 and p1_err = 1 in cycle 3; p1_rdata = 0.
REQ-025 reset_n pulses low during the ACCESS of a write of 0xDEADBEEF to address 5 -> strobes drop immediately; no done pulse; a later read of address 5 returns its prior value.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the RAM arbiter and its RAM clients.
// Holds the FSM state encoding and the default geometry.
package ram_arbiter_pkg;

    localparam int RA_ADDR_W = 9;
    localparam int RA_DATA_W = 32;
    localparam int RA_DEPTH  = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } ra_state_t;

    // Index of the port that did not win last time.
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, ties go to the port
// that was not granted last. Ports: req[1:0], last (index), grant one-hot.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (req == 2'b11): grant = other_port(last) ? 2'b10 : 2'b01;
            (req == 2'b01): grant = 2'b01;
            (req == 2'b10): grant = 2'b10;
            default:        grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM, one access at a time,
// fixed 3-edge latency (IDLE -> ACCESS -> RESP).
// Ports: clock/reset_n, per-port req/wr/addr/wdata in and done/err/rdata
// out, and the RAM side mem_addr/mem_wr/mem_rd/mem_wdata out, mem_rdata in.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RA_ADDR_W,
    parameter int DATA_W = RA_DATA_W,
    parameter int DEPTH  = RA_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    ra_state_t         state;
    logic              last_grant;
    logic              cur;
    logic              oor;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              sel;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [DATA_W-1:0] rd_next;

    assign req = {p1_req, p0_req};

    rr_arb2 u_rr (
        .req   (req),
        .last  (last_grant),
        .grant (grant)
    );

    assign sel       = grant[1];
    assign sel_wr    = sel ? p1_wr    : p0_wr;
    assign sel_addr  = sel ? p1_addr  : p0_addr;
    assign sel_wdata = sel ? p1_wdata : p0_wdata;
    assign in_range  = (32'(sel_addr) < DEPTH_U);

    // Only sample the RAM bus while it is actually driven; an
    // out-of-range access returns zero.
    always_comb begin
        rd_next = '0;
        if (!oor && mem_rd)
            rd_next = mem_rdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            cur        <= 1'b0;
            oor        <= 1'b0;
            mem_addr   <= '0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wdata  <= '0;
            p0_done    <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_done    <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        state      <= ST_ACCESS;
                        cur        <= sel;
                        last_grant <= sel;
                        oor        <= ~in_range;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_wr     <= in_range & sel_wr;
                        mem_rd     <= in_range & ~sel_wr;
                    end
                end
                ST_ACCESS: begin
                    state  <= ST_RESP;
                    mem_wr <= 1'b0;
                    mem_rd <= 1'b0;
                    if (!cur) begin
                        p0_done <= 1'b1;
                        p0_err  <= oor;
                        if (oor || mem_rd)
                            p0_rdata <= rd_next;
                    end else begin
                        p1_done <= 1'b1;
                        p1_err  <= oor;
                        if (oor || mem_rd)
                            p1_rdata <= rd_next;
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    p0_done <= 1'b0;
                    p0_err  <= 1'b0;
                    p1_done <= 1'b0;
                    p1_err  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
